// File: rtl/rlc_game_button_pio.sv
// Avalon-MM input PIO for the game buttons: two-flop synchroniser, per-bit
// debounce, edge capture into a write-1-to-clear register and a masked level irq.
module rlc_game_button_pio #(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = 1000000,
  parameter int   EDGE_TYPE       = 1,
  parameter logic IDLE_LEVEL      = 1'b1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam int              CW        = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_TC    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_WORD = {WIDTH{IDLE_LEVEL}};

  logic [WIDTH-1:0] sync1_q, sync2_q;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] edgecap_q, edgecap_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic [WIDTH-1:0] rise, fall, edge_det, clr;
  logic             wr_en;
  logic             unused_wdata;

  assign unused_wdata = ^writedata;
  assign wr_en        = chipselect & ~write_n;

  // A bit only moves once sync2 has disagreed with db for DEBOUNCE_CYCLES in a row.
  always_comb begin
    db_d = db_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = '0;
      if (sync2_q[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_TC) begin
        db_d[i]  = sync2_q[i];
        cnt_d[i] = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  always_comb begin
    rise = db_d & ~db_q;
    fall = ~db_d & db_q;
    if (EDGE_TYPE == 0) begin
      edge_det = rise;
    end else if (EDGE_TYPE == 1) begin
      edge_det = fall;
    end else begin
      edge_det = rise | fall;
    end
  end

  // Set wins over clear so an edge arriving with a clear is never lost.
  always_comb begin
    clr        = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    edgecap_d  = edge_det | (edgecap_q & ~clr);
    irq_mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : irq_mask_q;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      2'd0:    readdata_d[WIDTH-1:0] = db_q;
      2'd2:    readdata_d[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata_d[WIDTH-1:0] = edgecap_q;
      default: readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q    <= IDLE_WORD;
      sync2_q    <= IDLE_WORD;
      db_q       <= IDLE_WORD;
      cnt_q      <= '{default: '0};
      edgecap_q  <= '0;
      irq_mask_q <= '0;
      readdata_q <= '0;
    end else begin
      sync1_q    <= in_port;
      sync2_q    <= sync1_q;
      db_q       <= db_d;
      cnt_q      <= cnt_d;
      edgecap_q  <= edgecap_d;
      irq_mask_q <= irq_mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(edgecap_q & irq_mask_q);

endmodule

// File: tb/tb_rlc_game_button_pio.sv
// Scoreboard bench for rlc_game_button_pio with WIDTH=4, DEBOUNCE_CYCLES=4,
// falling-edge capture and idle-high inputs.
module tb_rlc_game_button_pio;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  rlc_game_button_pio #(
    .WIDTH(WIDTH), .DEBOUNCE_CYCLES(4), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .readdata(readdata),
    .in_port(in_port), .irq(irq)
  );

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic issue_read(input logic [1:0] a, input logic [31:0] e);
    @(negedge clk);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    logic [31:0] e;
    reset_n = 1'b0; in_port = 4'hF; address = 2'd0; chipselect = 1'b0;
    write_n = 1'b1; writedata = '0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (irq !== 1'b0 || readdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_hold: irq=%b readdata=%h expected irq=0 readdata=0", irq, readdata);
      end
    end
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      if (a == 1) continue;
      issue_read(a[1:0], (a == 0) ? 32'hF : 32'h0);
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e || irq !== 1'b0) begin
        errors++;
        $display("FAIL reset_read%0d: readdata=%h irq=%b expected %h irq=0", a, readdata, irq, e);
      end
      chipselect = 1'b0;
    end
  endtask

  task automatic test_debounce;
    logic [31:0] e;
    @(negedge clk);
    in_port = 4'hE; address = 2'd0; chipselect = 1'b1; write_n = 1'b1;
    // readdata after edge k shows db as it was before edge k; db falls at edge 6
    for (int k = 1; k <= 8; k++) exp_q.push_back((k <= 6) ? 32'hF : 32'hE);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e || irq !== 1'b0) begin
        errors++;
        $display("FAIL debounce_edge%0d: readdata=%h irq=%b expected %h irq=0", k, readdata, irq, e);
      end
    end
    chipselect = 1'b0;
    issue_read(2'd3, 32'h1);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL debounce_edgecap: readdata=%h expected %h", readdata, e);
    end
    chipselect = 1'b0;
    bus_write(2'd2, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL mask_irq: irq=%b expected 1", irq);
    end
  endtask

  task automatic test_rising_ignored;
    logic [31:0] e;
    @(negedge clk);
    in_port = 4'hF; address = 2'd0; chipselect = 1'b1;
    for (int k = 1; k <= 8; k++) exp_q.push_back((k <= 6) ? 32'hE : 32'hF);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e || irq !== 1'b1) begin
        errors++;
        $display("FAIL rise_edge%0d: readdata=%h irq=%b expected %h irq=1", k, readdata, irq, e);
      end
    end
    chipselect = 1'b0;
    issue_read(2'd3, 32'h1);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL rise_edgecap: readdata=%h expected %h", readdata, e);
    end
    chipselect = 1'b0;
  endtask

  task automatic test_glitch;
    logic [31:0] e;
    bus_write(2'd2, 32'h0);
    bus_write(2'd3, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL glitch_setup_irq: irq=%b expected 0", irq);
    end
    @(negedge clk);
    in_port = 4'hB; address = 2'd0; chipselect = 1'b1;
    for (int k = 1; k <= 10; k++) exp_q.push_back(32'hF);
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 3) in_port = 4'hF;
      e = exp_q.pop_front();
      checks++;
      if (readdata !== e || irq !== 1'b0) begin
        errors++;
        $display("FAIL glitch_cycle%0d: readdata=%h irq=%b expected %h irq=0", k, readdata, irq, e);
      end
    end
    chipselect = 1'b0;
    issue_read(2'd3, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL glitch_edgecap: readdata=%h expected %h", readdata, e);
    end
    chipselect = 1'b0;
  endtask

  task automatic test_w1c;
    logic [31:0] e;
    @(negedge clk);
    in_port = 4'hC;
    repeat (8) @(negedge clk);
    issue_read(2'd3, 32'h3);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL w1c_both: readdata=%h expected %h", readdata, e);
    end
    chipselect = 1'b0;
    bus_write(2'd2, 32'h3);
    bus_write(2'd3, 32'h1);
    issue_read(2'd3, 32'h2);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e || irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_bit0: readdata=%h irq=%b expected %h irq=1", readdata, irq, e);
    end
    chipselect = 1'b0;
    @(negedge clk);
    in_port = 4'hE;
    repeat (8) @(negedge clk);
    // new falling edge on bit 1 lands on edge 6, the same edge as the clear
    in_port = 4'hC;
    repeat (5) @(negedge clk);
    address = 2'd3; writedata = 32'h2; chipselect = 1'b1; write_n = 1'b0;
    @(negedge clk);
    chipselect = 1'b0; write_n = 1'b1;
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL w1c_set_wins_irq: irq=%b expected 1", irq);
    end
    issue_read(2'd3, 32'h2);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL w1c_set_wins: readdata=%h expected %h", readdata, e);
    end
    chipselect = 1'b0;
    bus_write(2'd3, 32'h2);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL w1c_clear_irq: irq=%b expected 0", irq);
    end
  endtask

  task automatic test_isolation;
    logic [31:0] e;
    bus_write(2'd0, 32'hFFFF_FFFF);
    bus_write(2'd1, 32'hFFFF_FFFF);
    issue_read(2'd0, 32'hC);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL iso_data: readdata=%h expected %h", readdata, e);
    end
    issue_read(2'd1, 32'h0);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e) begin
      errors++;
      $display("FAIL iso_addr1: readdata=%h expected %h", readdata, e);
    end
    chipselect = 1'b0;
    bus_write(2'd2, 32'hFFFF_FFFF);
    issue_read(2'd2, 32'hF);
    @(negedge clk);
    e = exp_q.pop_front();
    checks++;
    if (readdata !== e || irq !== 1'b0) begin
      errors++;
      $display("FAIL iso_mask: readdata=%h irq=%b expected %h irq=0", readdata, irq, e);
    end
    chipselect = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [31:0] e;
    logic [1:0]  seq [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [31:0] val [4] = '{32'hC, 32'h0, 32'hF, 32'h0};
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b1;
    address = seq[0]; exp_q.push_back(val[seq[0]]);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL b2b_empty%0d: scoreboard empty", i);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (readdata !== e) begin
          errors++;
          $display("FAIL b2b_read%0d: readdata=%h expected %h", i, readdata, e);
        end
      end
      if (i < 5) begin
        address = seq[i]; exp_q.push_back(val[seq[i]]);
      end
    end
    chipselect = 1'b0;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_rising_ignored();
    test_glitch();
    test_w1c();
    test_isolation();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
